// File: rtl/imem_arbiter.sv
// Two-requester round-robin arbiter in front of a shared instruction memory.
// One memory transaction in flight; timed-out responses are drained later.
module imem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic              m0_req_valid,
   input  logic [ADDR_W-1:0] m0_req_addr,
   output logic              m0_req_ready,
   output logic              m0_resp_valid,
   output logic [DATA_W-1:0] m0_resp_data,
   output logic              m0_resp_err,
   input  logic              m0_resp_ready,

   input  logic              m1_req_valid,
   input  logic [ADDR_W-1:0] m1_req_addr,
   output logic              m1_req_ready,
   output logic              m1_resp_valid,
   output logic [DATA_W-1:0] m1_resp_data,
   output logic              m1_resp_err,
   input  logic              m1_resp_ready,

   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              mem_resp_ready,

   output logic              busy
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT    = 2'd2;
   localparam logic [1:0] DELIVER = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   logic              drain_q, drain_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;

   logic gnt0;
   logic gnt1;
   logic resp_hs;

   // Grant is gated by reset_n so ready drops the instant reset asserts.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset_n && state_q == IDLE) begin
         if (m0_req_valid && m1_req_valid) begin
            gnt0 = last_grant_q;
            gnt1 = !last_grant_q;
         end else begin
            gnt0 = m0_req_valid;
            gnt1 = m1_req_valid;
         end
      end
   end

   assign resp_hs = owner_q ? m1_resp_ready : m0_resp_ready;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      drain_d      = drain_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      data_d       = data_q;
      err_d        = err_q;

      // The first response after a timeout belongs to the abandoned fetch.
      if (drain_q && mem_resp_valid) begin
         drain_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (gnt0 || gnt1) begin
               owner_d = gnt1;
               addr_d  = gnt1 ? m1_req_addr : m0_req_addr;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_req_ready && !drain_q) begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_resp_valid) begin
               data_d  = mem_resp_data;
               err_d   = 1'b0;
               state_d = DELIVER;
            end else if (cnt_q == CNT_MAX) begin
               data_d  = '0;
               err_d   = 1'b1;
               drain_d = 1'b1;
               state_d = DELIVER;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DELIVER: begin
            if (resp_hs) begin
               last_grant_d = owner_q;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         drain_q      <= 1'b0;
         cnt_q        <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         drain_q      <= drain_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         err_q        <= err_d;
      end
   end

   assign m0_req_ready   = gnt0;
   assign m1_req_ready   = gnt1;

   assign mem_req_valid  = (state_q == ISSUE) && !drain_q;
   assign mem_req_addr   = addr_q;
   assign mem_resp_ready = (state_q == WAIT) || drain_q;

   assign m0_resp_valid  = (state_q == DELIVER) && !owner_q;
   assign m1_resp_valid  = (state_q == DELIVER) && owner_q;
   assign m0_resp_data   = data_q;
   assign m1_resp_data   = data_q;
   assign m0_resp_err    = err_q;
   assign m1_resp_err    = err_q;

   assign busy           = (state_q != IDLE);

endmodule
